// File: rtl/adc_row_packer_if.sv
// Downstream FIFO write port of the ADC row packer.
// The packer drives wr_en/din; the FIFO returns its full flag.
interface adc_row_packer_if;
    logic        fifo_wr_en;
    logic [31:0] fifo_din;
    logic        fifo_full;

    modport master (output fifo_wr_en, output fifo_din, input fifo_full);
    modport slave  (input fifo_wr_en, input fifo_din, output fifo_full);
endinterface

// File: rtl/adc_row_packer.sv
// Packs ADC readout samples into header/data/trailer 32-bit words.
// A small skid buffer sits in front of the registered FIFO write port.
module adc_row_packer #(
    parameter int unsigned BUF_DEPTH = 4,
    parameter logic [15:0] HDR_TAG   = 16'hF0A5
) (
    input  logic                    TX_CLK,
    input  logic                    rst_n,
    input  logic                    re_busy,
    input  logic                    ADC_DATA_VALID,
    input  logic [16:0]             DIGOUT,
    input  logic [9:0]              NUM_ROW,
    adc_row_packer_if.master        fifo,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    ovf_sticky,
    output logic [15:0]             drop_cnt,
    output logic [15:0]             frame_cnt
);
    localparam int unsigned AW      = $clog2(BUF_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_DATA    = 2'd2,
        ST_TRAILER = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t         state_r, state_nx_s;
    logic           re_busy_d_r, valid_d_r, armed_r;
    logic [9:0]     num_row_r, row_idx_r, row_inc_s;
    logic [15:0]    sample_cnt_r, drop_cnt_r, frame_cnt_r;
    logic           frame_ovf_r, ovf_sticky_r, frame_done_r, busy_r;
    logic [31:0]    mem_r [BUF_DEPTH];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [AW:0]    count_r;
    logic           wr_en_r;
    logic [31:0]    din_r;

    logic           start_s, vfall_s, full_s, pop_s, push_s;
    logic [31:0]    push_word_s;
    logic           sample_s, drop_s, row_step_s, done_s, exit_s;

    // armed_r blocks a frame start until re_busy has been seen low after reset
    assign start_s   = re_busy & ~re_busy_d_r & armed_r;
    assign vfall_s   = valid_d_r & ~ADC_DATA_VALID;
    assign full_s    = (count_r == DEPTH_C);
    assign pop_s     = (count_r != '0) & ~fifo.fifo_full;
    assign row_inc_s = row_idx_r + 10'd1;

    assign fifo.fifo_wr_en = wr_en_r;
    assign fifo.fifo_din   = din_r;
    assign frame_done      = frame_done_r;
    assign busy            = busy_r;
    assign ovf_sticky      = ovf_sticky_r;
    assign drop_cnt        = drop_cnt_r;
    assign frame_cnt       = frame_cnt_r;

    // Next-state and push/drop decode
    always_comb begin
        state_nx_s  = state_r;
        push_s      = 1'b0;
        push_word_s = 32'h0000_0000;
        sample_s    = 1'b0;
        drop_s      = 1'b0;
        row_step_s  = 1'b0;
        done_s      = 1'b0;
        exit_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nx_s = ST_HEADER;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_HEADER: begin
                drop_s = ADC_DATA_VALID;
                if (!full_s) begin
                    push_s      = 1'b1;
                    push_word_s = {HDR_TAG, frame_cnt_r};
                    state_nx_s  = ST_DATA;
                end else begin
                    state_nx_s  = ST_HEADER;
                end
            end
            ST_DATA: begin
                row_step_s = vfall_s;
                exit_s     = ~re_busy |
                             (vfall_s & (num_row_r != 10'd0) & (row_inc_s == num_row_r));
                if (exit_s) begin
                    state_nx_s = ST_TRAILER;
                end else if (ADC_DATA_VALID) begin
                    sample_s    = 1'b1;
                    push_word_s = {4'hA, row_idx_r, 1'b0, DIGOUT};
                    // a pop in the same cycle frees the slot this push needs
                    if (!full_s || pop_s) begin
                        push_s = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_TRAILER: begin
                if (!full_s) begin
                    push_s      = 1'b1;
                    push_word_s = {4'hE, frame_ovf_r, 1'b0, row_idx_r, sample_cnt_r};
                    done_s      = 1'b1;
                    state_nx_s  = ST_IDLE;
                end else begin
                    state_nx_s  = ST_TRAILER;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, edge detectors, frame counters and status flags
    always_ff @(posedge TX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            re_busy_d_r  <= 1'b0;
            valid_d_r    <= 1'b0;
            armed_r      <= 1'b0;
            num_row_r    <= 10'd0;
            row_idx_r    <= 10'd0;
            sample_cnt_r <= 16'd0;
            frame_ovf_r  <= 1'b0;
            ovf_sticky_r <= 1'b0;
            drop_cnt_r   <= 16'd0;
            frame_cnt_r  <= 16'd0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            re_busy_d_r  <= re_busy;
            valid_d_r    <= ADC_DATA_VALID;
            armed_r      <= armed_r | ~re_busy;
            busy_r       <= (state_nx_s != ST_IDLE);
            frame_done_r <= done_s;
            if (done_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            if (drop_s) begin
                ovf_sticky_r <= 1'b1;
                drop_cnt_r   <= sat_inc16(drop_cnt_r);
            end
            if ((state_r == ST_IDLE) && start_s) begin
                num_row_r    <= NUM_ROW;
                row_idx_r    <= 10'd0;
                sample_cnt_r <= 16'd0;
                frame_ovf_r  <= 1'b0;
            end else begin
                if (row_step_s) begin
                    row_idx_r <= row_inc_s;
                end
                if (sample_s) begin
                    sample_cnt_r <= sat_inc16(sample_cnt_r);
                end
                if (drop_s) begin
                    frame_ovf_r <= 1'b1;
                end
            end
        end
    end

    // Skid buffer pointers/occupancy and registered FIFO write port
    always_ff @(posedge TX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            wr_en_r  <= 1'b0;
            din_r    <= 32'h0000_0000;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                din_r    <= mem_r[rd_ptr_r];
                wr_en_r  <= 1'b1;
            end else begin
                wr_en_r  <= 1'b0;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Buffer storage; stale contents are harmless because count_r gates reads
    always_ff @(posedge TX_CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_word_s;
        end
    end
endmodule

// File: tb/tb_adc_row_packer.sv
// Directed bench for adc_row_packer: table of nominal frames plus
// hand-written back-pressure, early-end and async-reset sequences.
module tb_adc_row_packer;
    logic        TX_CLK = 1'b0;
    logic        rst_n;
    logic        re_busy;
    logic        ADC_DATA_VALID;
    logic [16:0] DIGOUT;
    logic [9:0]  NUM_ROW;
    logic        frame_done, busy, ovf_sticky;
    logic [15:0] drop_cnt, frame_cnt;

    adc_row_packer_if fifo_if ();

    adc_row_packer #(.BUF_DEPTH(4), .HDR_TAG(16'hF0A5)) dut (
        .TX_CLK         (TX_CLK),
        .rst_n          (rst_n),
        .re_busy        (re_busy),
        .ADC_DATA_VALID (ADC_DATA_VALID),
        .DIGOUT         (DIGOUT),
        .NUM_ROW        (NUM_ROW),
        .fifo           (fifo_if),
        .frame_done     (frame_done),
        .busy           (busy),
        .ovf_sticky     (ovf_sticky),
        .drop_cnt       (drop_cnt),
        .frame_cnt      (frame_cnt)
    );

    always #5 TX_CLK = ~TX_CLK;

    typedef struct {
        logic [9:0]  num_row;
        int          rows;
        int          spr;
        logic [31:0] exp_hdr;
        logic [31:0] exp_trl;
        logic [15:0] exp_fcnt;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] out_q [$];
    logic [31:0] exp_q [$];
    int          done_cnt = 0;
    int          n_cmp    = 0;
    int          n_fail   = 0;

    // Capture every FIFO write and frame_done pulse away from the active edge
    always @(negedge TX_CLK) begin
        if (fifo_if.fifo_wr_en) out_q.push_back(fifo_if.fifo_din);
        if (frame_done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge TX_CLK);
        #1;
    endtask

    function automatic logic [16:0] dval(input int r, input int s);
        return {1'b1, 8'(r), 8'(s)};
    endfunction

    function automatic logic [31:0] dword(input int r, input int s);
        return {4'hA, 10'(r), 1'b0, dval(r, s)};
    endfunction

    task automatic frame_start(input logic [9:0] nr);
        re_busy = 1'b1;
        NUM_ROW = nr;
        tick();
        tick();
    endtask

    task automatic sample(input int r, input int s);
        ADC_DATA_VALID = 1'b1;
        DIGOUT         = dval(r, s);
        tick();
    endtask

    task automatic row_end();
        ADC_DATA_VALID = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 200) begin
            tick();
            k++;
        end
        chk("frame_done_timeout", 32'(done_cnt), 32'(target));
    endtask

    task automatic check_words(input string name);
        int n;
        chk({name, "_word_count"}, 32'(out_q.size()), 32'(exp_q.size()));
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_word%0d", name, i), out_q[i], exp_q[i]);
    endtask

    task automatic run_frame(input vec_t v, input string name);
        int base_done;
        base_done = done_cnt;
        out_q.delete();
        exp_q.delete();
        exp_q.push_back(v.exp_hdr);
        frame_start(v.num_row);
        for (int r = 0; r < v.rows; r++) begin
            for (int s = 0; s < v.spr; s++) begin
                sample(r, s);
                exp_q.push_back(dword(r, s));
            end
            row_end();
        end
        tick();
        re_busy = 1'b0;
        wait_done(base_done + 1);
        repeat (4) tick();
        exp_q.push_back(v.exp_trl);
        check_words(name);
        chk({name, "_done_pulses"}, 32'(done_cnt), 32'(base_done + 1));
        chk({name, "_frame_cnt"}, 32'(frame_cnt), 32'(v.exp_fcnt));
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        chk({name, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        vecs[0] = '{10'd2, 2, 3, 32'hF0A5_0000, 32'hE002_0006, 16'd1};
        vecs[1] = '{10'd0, 4, 2, 32'hF0A5_0001, 32'hE004_0008, 16'd2};
        vecs[2] = '{10'd1, 1, 5, 32'hF0A5_0002, 32'hE001_0005, 16'd3};
        vecs[3] = '{10'd3, 3, 1, 32'hF0A5_0003, 32'hE003_0003, 16'd4};
        vecs[4] = '{10'd1, 1, 2, 32'hF0A5_0000, 32'hE001_0002, 16'd1};

        rst_n = 1'b0; re_busy = 1'b1; ADC_DATA_VALID = 1'b0;
        DIGOUT = 17'd0; NUM_ROW = 10'd0; fifo_if.fifo_full = 1'b0;
        tick(); tick();
        chk("rst_wr_en", 32'(fifo_if.fifo_wr_en), 32'd0);
        chk("rst_din", fifo_if.fifo_din, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);

        // re_busy already high at reset release must not start a frame
        rst_n = 1'b1;
        out_q.delete();
        repeat (5) tick();
        chk("release_hi_busy", 32'(busy), 32'd0);
        chk("release_hi_words", 32'(out_q.size()), 32'd0);
        re_busy = 1'b0;
        tick(); tick();

        for (int i = 0; i < 4; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Back-pressure: 6-sample row into a 4-deep buffer with the FIFO full
        out_q.delete(); exp_q.delete();
        fifo_if.fifo_full = 1'b1;
        frame_start(10'd1);
        for (int s = 0; s < 6; s++) sample(0, s);
        row_end();
        chk("bp_drop_cnt", 32'(drop_cnt), 32'd3);
        chk("bp_ovf_sticky", 32'(ovf_sticky), 32'd1);
        chk("bp_busy_held", 32'(busy), 32'd1);
        fifo_if.fifo_full = 1'b0;
        wait_done(done_cnt + 1);
        re_busy = 1'b0;
        repeat (4) tick();
        exp_q = '{32'hF0A5_0004, dword(0, 0), dword(0, 1), dword(0, 2), 32'hE801_0006};
        check_words("bp");

        // Full buffer: FIFO frees up in the same cycle a sample arrives
        out_q.delete();
        fifo_if.fifo_full = 1'b1;
        frame_start(10'd1);
        for (int s = 0; s < 3; s++) sample(0, s);
        fifo_if.fifo_full = 1'b0;
        sample(0, 3);
        row_end();
        wait_done(done_cnt + 1);
        re_busy = 1'b0;
        repeat (4) tick();
        exp_q = '{32'hF0A5_0005, dword(0, 0), dword(0, 1), dword(0, 2), dword(0, 3),
                  32'hE001_0004};
        check_words("pushpop");
        chk("pushpop_drop_cnt", 32'(drop_cnt), 32'd3);

        // Early end: re_busy falls in row 1 together with a valid sample
        out_q.delete();
        frame_start(10'd5);
        sample(0, 0); sample(0, 1); row_end();
        sample(1, 0);
        ADC_DATA_VALID = 1'b1; DIGOUT = 17'h1FFFF; re_busy = 1'b0;
        tick();
        ADC_DATA_VALID = 1'b0;
        wait_done(done_cnt + 1);
        repeat (4) tick();
        exp_q = '{32'hF0A5_0006, dword(0, 0), dword(0, 1), dword(1, 0), 32'hE001_0003};
        check_words("early");
        chk("early_drop_cnt", 32'(drop_cnt), 32'd3);
        chk("early_frame_cnt", 32'(frame_cnt), 32'd7);

        // Async reset mid-DATA with header plus one sample buffered
        out_q.delete();
        fifo_if.fifo_full = 1'b1;
        frame_start(10'd0);
        sample(0, 0);
        ADC_DATA_VALID = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wr_en", 32'(fifo_if.fifo_wr_en), 32'd0);
        chk("arst_din", fifo_if.fifo_din, 32'd0);
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("arst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("arst_ovf_sticky", 32'(ovf_sticky), 32'd0);
        fifo_if.fifo_full = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("arst_no_words", 32'(out_q.size()), 32'd0);
        chk("arst_busy_after", 32'(busy), 32'd0);
        re_busy = 1'b0;
        tick(); tick();
        run_frame(vecs[4], "vec4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_row_packer.md
ADC_ROW_PACKER -- requirements
Module: adc_row_packer

Interface
REQ-001 Parameter BUF_DEPTH, default 4, depth of the internal skid buffer in 32-bit words (power of two, minimum 2).
REQ-002 Parameter HDR_TAG, default 16'hF0A5, upper half of the frame header word.
REQ-003 Clocking and reset: one clock, TX_CLK; reset rst_n is asynchronous and active-low.
REQ-004 TX_CLK  input  1  readout clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 re_busy  input  1  readout frame active; a rising edge starts a frame, a falling edge ends it.
REQ-007 ADC_DATA_VALID  input  1  DIGOUT carries one valid sample this cycle; a falling edge marks end of row.
REQ-008 DIGOUT  input  17  ADC sample word.
REQ-009 NUM_ROW  input  10  rows per frame; sampled at frame start; 0 = end frame only on re_busy fall.
REQ-010 fifo_full  input  1  downstream FIFO cannot accept a word.
REQ-011 fifo_wr_en  output  1  one-cycle write strobe to the downstream FIFO, registered.
REQ-012 fifo_din  output  32  word written when fifo_wr_en=1, registered.
REQ-013 frame_done  output  1  one-cycle pulse in the cycle after the trailer is pushed.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 ovf_sticky  output  1  set on any dropped word; cleared only by reset.
REQ-016 drop_cnt  output  16  dropped data samples, saturating at 16'hFFFF.
REQ-017 frame_cnt  output  16  completed frames, wraps at 16'hFFFF to 0.

Function
REQ-018 FSM states are IDLE, HEADER, DATA, TRAILER; re_busy is registered once (re_busy_d) for edge detection.
REQ-019 IDLE -> HEADER on re_busy & ~re_busy_d; latch NUM_ROW; clear row_idx, sample_cnt, frame_ovf.
REQ-020 HEADER pushes {HDR_TAG, frame_cnt} when the buffer has space, then goes to DATA; it holds while the buffer is full.
REQ-021 In DATA, each cycle with ADC_DATA_VALID=1 pushes {4'hA, row_idx[9:0], 1'b0, DIGOUT[16:0]}, and sample_cnt increments, saturating at 16'hFFFF.
REQ-022 An ADC_DATA_VALID falling edge (registered) in DATA increments row_idx.
REQ-023 DATA -> TRAILER when row_idx equals the latched NUM_ROW (non-zero) after increment, or when re_busy=0; a valid sample arriving in the exit cycle is discarded and not counted.
REQ-024 TRAILER pushes {4'hE, frame_ovf, 1'b0, row_idx[9:0], sample_cnt[15:0]} when space exists, then pulses frame_done, increments frame_cnt and goes to IDLE; it holds while the buffer is full.
REQ-025 ADC_DATA_VALID is ignored in IDLE and TRAILER; a valid sample in HEADER is dropped and counted as dropped.
REQ-026 A data push when the buffer is full and no pop occurs in the same cycle is dropped: drop_cnt+1 (saturating), ovf_sticky=1, frame_ovf=1.
REQ-027 Simultaneous push and pop on a full buffer is accepted without drop.
REQ-028 Output stage: at each edge, if the buffer is non-empty and fifo_full=0, pop the head into fifo_din and set fifo_wr_en=1; otherwise fifo_wr_en=0 and fifo_din holds.
REQ-029 Latency: a word pushed at edge k appears with fifo_wr_en=1 after edge k+1 when fifo_full=0 at edge k+1; words leave in push order.
REQ-030 A new re_busy rising edge while not in IDLE is ignored.

Reset
REQ-031 rst_n=0 asynchronously forces: state IDLE; fifo_wr_en=0; fifo_din=0; frame_done=0; busy=0; ovf_sticky=0; drop_cnt=0; frame_cnt=0; buffer empty; row_idx=0; sample_cnt=0; re_busy_d=0.
REQ-032 Reset mid-frame discards all buffered words; no trailer is emitted.
REQ-033 After rst_n deasserts, a frame starts only on a fresh re_busy rising edge; re_busy already high at release does not start a frame.

Verification
REQ-034 Nominal: NUM_ROW=2, 3 samples per row, fifo_full=0 -> 8 words out: header 32'hF0A50000, six 4'hA data words with row 0,0,0,1,1,1, trailer 32'hE0020006; frame_done pulses once; frame_cnt=1.
REQ-035 Back-pressure: fifo_full=1 through a 6-sample row with BUF_DEPTH=4 -> header plus 3 samples buffered, 3 samples dropped, drop_cnt=3, ovf_sticky=1, trailer bit 27=1 after fifo_full is released.
REQ-036 Early end: NUM_ROW=5, re_busy falls in row 1 while ADC_DATA_VALID=1 -> that sample is discarded, trailer row field=1, no drop counted.
REQ-037 NUM_ROW=0: 4 rows of 2 samples, then re_busy falls -> trailer 32'hE0040008.
REQ-038 Async reset: rst_n pulsed low mid-DATA with 2 words buffered -> outputs go to reset values immediately, no further fifo_wr_en, frame_cnt=0.
REQ-039 Full-buffer push/pop: buffer full, fifo_full drops the same cycle a valid sample arrives -> sample accepted, drop_cnt unchanged.
